// File: rtl/multdiv_seq_if.sv
// Bundle of operand, start, result and status signals for multdiv_seq.
// master drives operands and start pulses; slave is the multiplier/divider.
interface multdiv_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_result_hi;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_result_hi,
    input  data_exception,
    input  data_resultRDY,
    input  data_busy
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_result_hi,
    output data_exception,
    output data_resultRDY,
    output data_busy
  );
endinterface

// File: rtl/multdiv_seq.sv
// Sequential signed multiplier/divider sharing one shift/add datapath; WIDTH+1 cycle latency.
// Optional macro MULTDIV_HI_EN exposes the high product half / signed remainder on data_result_hi.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  multdiv_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             w_start;
  logic             w_iter;
  logic             w_fix;

  logic             r_is_div;
  logic             r_a_neg;
  logic             r_b_neg;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic             w_sub;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  logic             w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic             w_mul_ovf;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_quot_s;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_exc;

  assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign w_abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A start pulse always wins, abandoning whatever op is in RUN or FIX.
  always_comb begin
    w_state_next = r_state;
    w_iter       = 1'b0;
    w_fix        = 1'b0;
    if (w_start) begin
      w_state_next = S_RUN;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_IDLE;
        S_RUN: begin
          w_iter = 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_state_next = S_FIX;
          end
        end
        S_FIX: begin
          w_fix        = 1'b1;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Shared adder: multiply adds |B| into the high half, divide trial-subtracts |B|.
  always_comb begin
    w_sub = r_is_div;
    if (r_is_div) begin
      w_x = {r_hi, r_lo[WIDTH-1]};
      w_y = {1'b0, r_b};
    end else begin
      w_x = {1'b0, r_hi};
      w_y = r_lo[0] ? {1'b0, r_b} : '0;
    end
    w_sum = {1'b0, w_x} + {1'b0, (w_sub ? ~w_y : w_y)} + {{(WIDTH + 1){1'b0}}, w_sub};
    if (r_is_div) begin
      w_hi_next = w_sum[WIDTH+1] ? w_sum[WIDTH-1:0] : w_x[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], w_sum[WIDTH+1]};
    end else begin
      w_hi_next = w_sum[WIDTH:1];
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_neg     = r_a_neg ^ r_b_neg;
  assign w_prod    = {r_hi, r_lo};
  assign w_prod_s  = w_neg ? -w_prod : w_prod;
  assign w_mul_ovf = (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});
  assign w_b_zero  = (r_b == '0);
  assign w_quot_s  = w_neg ? -r_lo : r_lo;
  // Only MIN / -1 yields a positive quotient with the top bit set.
  assign w_div_ovf = ~w_neg & r_lo[WIDTH-1];

  always_comb begin
    w_res = '0;
    w_exc = 1'b0;
    if (r_is_div) begin
      w_res = w_b_zero ? '0 : w_quot_s;
      w_exc = w_b_zero | w_div_ovf;
    end else begin
      w_res = w_prod_s[WIDTH-1:0];
      w_exc = w_mul_ovf;
    end
  end

`ifdef MULTDIV_HI_EN
  logic [WIDTH-1:0] r_result_hi;
  logic [WIDTH-1:0] w_res_hi;

  always_comb begin
    w_res_hi = '0;
    if (r_is_div) begin
      w_res_hi = w_b_zero ? '0 : (r_a_neg ? -r_hi : r_hi);
    end else begin
      w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result_hi <= '0;
    end else if (w_fix) begin
      r_result_hi <= w_res_hi;
    end
  end

  assign bus.data_result_hi = r_result_hi;
`else
  assign bus.data_result_hi = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_is_div <= ~bus.ctrl_MULT;
        r_a_neg  <= bus.data_operandA[WIDTH-1];
        r_b_neg  <= bus.data_operandB[WIDTH-1];
        r_hi     <= '0;
        r_lo     <= w_abs_a;
        r_b      <= w_abs_b;
        r_cnt    <= '0;
      end else if (w_iter) begin
        r_hi  <= w_hi_next;
        r_lo  <= w_lo_next;
        r_cnt <= r_cnt + 1'b1;
      end else if (w_fix) begin
        r_result <= w_res;
        r_exc    <= w_exc;
        r_rdy    <= 1'b1;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.data_busy      = (r_state != S_IDLE);

endmodule
